// File: rtl/bp_update_queue.sv
// rtl/bp_update_queue.sv - resolved-branch update FIFO feeding the bpcache write port with fetch-side forwarding
module bp_update_queue #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic                     in_taken,
  input  logic                     stall,
  input  logic                     flush,
  output logic [ADDR_W-1:0]        w_addr,
  output logic                     did_branch,
  output logic                     we,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic                     fwd_taken
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic              mem_taken [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              push;
  logic              pop;

  // Ready depends only on the registered count; a pop in the same cycle never frees a slot early.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (count != '0) && !stall && !flush;

  // Entry storage; only slots between rd_ptr and rd_ptr+count are ever read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr]  <= in_addr;
      mem_taken[wr_ptr] <= in_taken;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue and wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output register: one-cycle write pulse per popped entry; address and outcome hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we         <= 1'b0;
      w_addr     <= '0;
      did_branch <= 1'b0;
    end else if (pop) begin
      we         <= 1'b1;
      w_addr     <= mem_addr[rd_ptr];
      did_branch <= mem_taken[rd_ptr];
    end else begin
      we         <= 1'b0;
    end
  end

  // Forwarding lookup: the in-flight write is oldest, then FIFO entries oldest to youngest, so the last match wins.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_taken = 1'b0;
    if (we && (w_addr == fwd_addr)) begin
      fwd_hit   = 1'b1;
      fwd_taken = did_branch;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (mem_addr[rd_ptr + PW'(k)] == fwd_addr)) begin
        fwd_hit   = 1'b1;
        fwd_taken = mem_taken[rd_ptr + PW'(k)];
      end
    end
  end

endmodule

// File: tb/tb_bp_update_queue.sv
// tb/tb_bp_update_queue.sv - randomized self-checking bench for bp_update_queue against a queue-based model
`timescale 1ns/1ps
module tb_bp_update_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_addr = '0;
  logic       in_taken = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] w_addr;
  logic       did_branch;
  logic       we;
  logic [2:0] count;
  logic [7:0] fwd_addr = '0;
  logic       fwd_hit;
  logic       fwd_taken;

  bp_update_queue #(.ADDR_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_taken(in_taken), .stall(stall), .flush(flush),
    .w_addr(w_addr), .did_branch(did_branch), .we(we), .count(count),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_taken(fwd_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic       t;
  } ent_t;

  ent_t       q[$];
  logic       we_m;
  logic [7:0] waddr_m;
  logic       db_m;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    we_m    = 1'b0;
    waddr_m = '0;
    db_m    = 1'b0;
  endtask

  // Applies the queue rules to the inputs seen at the rising edge.
  task automatic model_edge();
    bit do_push, do_pop;
    ent_t e;
    do_push = in_valid && (q.size() < DEPTH) && !flush;
    do_pop  = (q.size() > 0) && !stall && !flush;
    if (flush) begin
      q.delete();
      we_m = 1'b0;
    end else begin
      if (do_pop) begin
        e = q.pop_front();
        we_m = 1'b1;
        waddr_m = e.a;
        db_m = e.t;
      end else begin
        we_m = 1'b0;
      end
      if (do_push) begin
        e.a = in_addr;
        e.t = in_taken;
        q.push_back(e);
      end
    end
  endtask

  task automatic compare_all();
    logic h, t;
    h = 1'b0;
    t = 1'b0;
    if (we_m && waddr_m == fwd_addr) begin
      h = 1'b1;
      t = db_m;
    end
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].a == fwd_addr) begin
        h = 1'b1;
        t = q[i].t;
      end
    end
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check("we", 32'(we), 32'(we_m));
    check("w_addr", 32'(w_addr), 32'(waddr_m));
    check("did_branch", 32'(did_branch), 32'(db_m));
    check("fwd_hit", 32'(fwd_hit), 32'(h));
    check("fwd_taken", 32'(fwd_taken), 32'(t));
  endtask

  // Called at a falling edge: drive inputs, let the rising edge happen, compare at the next falling edge.
  task automatic step(input logic v, input logic [7:0] a, input logic t,
                      input logic s, input logic f, input logic [7:0] fa);
    in_valid = v; in_addr = a; in_taken = t; stall = s; flush = f; fwd_addr = fa;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic s, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, s, 1'b0, 8'h00);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(we), 0);
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 256; i++) begin
      fwd_addr = 8'(i);
      #0.01;
      check("rst_fwd_hit", 32'(fwd_hit), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0, 2);

    // Single update: pushed at edge N, written during the cycle after edge N+1.
    step(1'b1, 8'h3A, 1'b1, 1'b0, 1'b0, 8'h3A);
    check("single_no_bypass", 32'(we), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3A);
    check("single_we", 32'(we), 1);
    check("single_addr", 32'(w_addr), 32'h3A);
    check("single_db", 32'(did_branch), 1);
    idle(1'b0, 1);
    check("single_we_off", 32'(we), 0);

    // Backpressure: fill while stalled, a fifth push is refused, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'(i & 1), 1'b1, 1'b0, 8'h13);
    step(1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 8'h14);
    check("bp_count_full", 32'(count), 4);
    check("bp_not_ready", 32'(in_ready), 0);
    check("bp_no_fifth", 32'(fwd_hit), 0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0, 1);
      check("bp_drain_we", 32'(we), 1);
      check("bp_drain_addr", 32'(w_addr), 32'(8'h10 + i));
    end
    idle(1'b0, 1);
    check("bp_done_we", 32'(we), 0);

    // Forwarding: youngest of two matching entries decides the outcome.
    step(1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 8'h20);
    step(1'b1, 8'h20, 1'b1, 1'b1, 1'b0, 8'h20);
    check("fwd_prio_hit", 32'(fwd_hit), 1);
    check("fwd_prio_taken", 32'(fwd_taken), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h21);
    check("fwd_miss_hit", 32'(fwd_hit), 0);
    check("fwd_miss_taken", 32'(fwd_taken), 0);
    idle(1'b0, 3);

    // Flush with a coincident push: everything, including the push, is discarded.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b1, 1'b0, 8'h40);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h55);
    check("flush_count", 32'(count), 0);
    check("flush_we", 32'(we), 0);
    check("flush_drop", 32'(fwd_hit), 0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0, 1);
      check("flush_quiet_we", 32'(we), 0);
    end

    // Wrap-around: light random traffic with no stall keeps occupancy low across many pointer wraps.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom), 1'b0, 1'b0, 8'($urandom));
      if (count > 3'd4) check("wrap_count_bound", 32'(count), 4);
    end
    idle(1'b0, 4);

    // Asynchronous reset in the middle of a drain kills the in-flight pulse immediately.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b1, 1'b1, 1'b0, 8'h60);
    idle(1'b0, 1);
    check("pre_rst_we", 32'(we), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(we), 0);
    check("async_rst_count", 32'(count), 0);
    check("async_rst_fwd", 32'(fwd_hit), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0, 2);

    // Random traffic with a narrow address range so forwarding hits are common.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 9) < 7), 8'(8'h20 + $urandom_range(0, 7)), 1'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0),
           8'(8'h20 + $urandom_range(0, 7)));
    end
    idle(1'b0, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
